n64adv_vpll_seq: RTL and testbench
==================================

N64ADV_VPLL_SEQ -- requirements
Module: n64adv_vpll_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles VPLL_ARESET is held high per PLL restart.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1048576: cycles to wait for synchronized lock before a retry.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256: cycles lock must stay continuously high before the clock switch.
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed lock attempts tolerated before fallback.
REQ-005 SHALL have port SYS_CLK  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port SRST  in  1  synchronous active-high reset, sampled on rising SYS_CLK.
REQ-007 SHALL have port USE_VPLL  in  1  level request from controller: 1 = run Tx from video PLL.
REQ-008 SHALL have port VPLL_LOCKED  in  1  asynchronous PLL lock indicator.
REQ-009 SHALL have port VPLL_ARESET  out  1  PLL reset, active-high.
REQ-010 SHALL have port VCLK_SEL  out  2  Tx clock select: 2'b00 = VCLK direct, 2'b01 = PLL output; other codes never driven.
REQ-011 SHALL have port TX_RST  out  1  Tx-domain reset request, active-high.
REQ-012 SHALL have port VPLL_ACTIVE  out  1  high only in state RUN_PLL.
REQ-013 SHALL have port VPLL_FAIL  out  1  sticky: retries exhausted.

Function
REQ-014 SHALL pass VPLL_LOCKED through a 2-flop synchronizer; "lock" below means the synchronized value (2-cycle latency).
REQ-015 SHALL implement states BYPASS, PLL_RST, WAIT_LOCK, SETTLE, SW_PRE, SW_POST, RUN_PLL, SW_BACK.
REQ-016 BYPASS: VCLK_SEL=00, VPLL_ARESET=1; on USE_VPLL=1 and VPLL_FAIL=0 -> PLL_RST, retry count cleared.
REQ-017 PLL_RST: VPLL_ARESET=1 for exactly RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: VPLL_ARESET=0; lock=1 -> SETTLE; timer reaching LOCK_TIMEOUT -> retry count+1, then PLL_RST if count<MAX_RETRY, else set VPLL_FAIL and -> BYPASS.
REQ-019 SETTLE: lock=0 at any cycle -> WAIT_LOCK with timer cleared; SETTLE_CYCLES consecutive lock cycles -> SW_PRE.
REQ-020 SW_PRE: TX_RST=1 for 4 cycles with VCLK_SEL unchanged, then VCLK_SEL<=01 and -> SW_POST.
REQ-021 SW_POST: TX_RST=1 for 8 further cycles -> RUN_PLL; TX_RST=0 in RUN_PLL.
REQ-022 RUN_PLL: USE_VPLL=0 -> SW_BACK.
REQ-023 SW_BACK: TX_RST=1 for 4 cycles, VCLK_SEL<=00, TX_RST=1 for 8 more cycles -> BYPASS with VPLL_ARESET=1.
REQ-024 USE_VPLL=0 in PLL_RST, WAIT_LOCK or SETTLE SHALL go to BYPASS next cycle; in SW_PRE/SW_POST the switch SHALL complete, then RUN_PLL exits to SW_BACK.
REQ-025 VCLK_SEL SHALL change only while TX_RST has been high at least 4 cycles.
REQ-026 All counters SHALL be sized by $clog2 of their parameter+1 and saturate, never wrap.
REQ-027 VPLL_FAIL SHALL clear only on SRST or on USE_VPLL falling edge.

Reset
REQ-028 On SRST: state BYPASS, VCLK_SEL=00, VPLL_ARESET=1, TX_RST=1, VPLL_ACTIVE=0, VPLL_FAIL=0, counters and synchronizer 0.
REQ-029 TX_RST SHALL remain 1 for 8 cycles after SRST release, then 0 in BYPASS.
REQ-030 SRST mid-switch SHALL force VCLK_SEL=00 on the same edge.

Configuration
REQ-031 Macro VPLL_LOCKLOSS_RECOVERY_EN defined: lock=0 for 2 consecutive cycles in RUN_PLL -> SW_BACK sequence then PLL_RST, retry count+1.
REQ-032 Macro undefined: lock loss in RUN_PLL SHALL be ignored; state stays RUN_PLL.

Structure
REQ-033 State encoding enum and TX_RST pre/post hold constants (4, 8) SHALL live in shared package n64adv_vpll_pkg.
REQ-034 The synchronizer SHALL be sub-module n64adv_sync2ff; the rest is a single FSM plus counters.

Verification
REQ-035 RST_CYCLES=16, SETTLE=256; USE_VPLL=1, lock high 40 cycles later -> VCLK_SEL=01 after 16+settle+4 cycles, VPLL_ACTIVE=1 8 cycles later.
REQ-036 LOCK_TIMEOUT=100, MAX_RETRY=3, lock never high -> 3 PLL_RST pulses, VPLL_FAIL=1, VCLK_SEL stays 00.
REQ-037 Lock drops once at settle cycle 100 -> restart of settle count; switch only after 256 clean cycles.
REQ-038 USE_VPLL 1->0 in RUN_PLL -> TX_RST high 12 cycles, VCLK_SEL=00 at cycle 4, ends in BYPASS.
REQ-039 SRST during SW_POST -> VCLK_SEL=00, TX_RST=1 next edge, all outputs at reset values.
REQ-040 With VPLL_LOCKLOSS_RECOVERY_EN, lock low 2 cycles in RUN_PLL -> SW_BACK then PLL_RST; without, VPLL_ACTIVE stays 1.

Source files
------------

// File: rtl/n64adv_vpll_pkg.sv
// n64adv_vpll_pkg: shared state encoding and Tx reset hold lengths for the video PLL sequencer
package n64adv_vpll_pkg;
    typedef enum logic [2:0] {
        BYPASS, PLL_RST, WAIT_LOCK, SETTLE, SW_PRE, SW_POST, RUN_PLL, SW_BACK
    } vpll_state_t;
    localparam int TX_PRE  = 4;
    localparam int TX_POST = 8;
endpackage

// File: rtl/n64adv_sync2ff.sv
// n64adv_sync2ff: two-flop synchronizer for the asynchronous PLL lock flag
module n64adv_sync2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;
    // Two back-to-back flops; the second stage is the only one the FSM sees
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/n64adv_vpll.sv
// n64adv_vpll_seq: video PLL restart/lock/clock-switch sequencer (optional VPLL_LOCKLOSS_RECOVERY_EN)
module n64adv_vpll_seq
    import n64adv_vpll_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic       SYS_CLK,
    input  logic       SRST,
    input  logic       USE_VPLL,
    input  logic       VPLL_LOCKED,
    output logic       VPLL_ARESET,
    output logic [1:0] VCLK_SEL,
    output logic       TX_RST,
    output logic       VPLL_ACTIVE,
    output logic       VPLL_FAIL
);
    localparam int TX_ALL = TX_PRE + TX_POST;
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TX_ALL + 1);
    localparam int NW = $clog2(MAX_RETRY + 1);

    vpll_state_t   state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [LW-1:0] lock_tmr_q, lock_tmr_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [TW-1:0] tx_cnt_q, tx_cnt_d;
    logic [NW-1:0] retry_q, retry_d;
    logic [1:0]    sel_q, sel_d;
    logic          fail_q, fail_d, use_q, use_d;
    logic          lock;
`ifdef VPLL_LOCKLOSS_RECOVERY_EN
    logic          loss_q, loss_d, recover_q, recover_d;
`endif

    n64adv_sync2ff u_sync (.clk(SYS_CLK), .rst(SRST), .d(VPLL_LOCKED), .q(lock));

    // State and counter registers; reset parks the Tx clock on VCLK at the same edge
    always_ff @(posedge SYS_CLK) begin
        if (SRST) begin
            state_q      <= BYPASS;
            rst_cnt_q    <= '0;
            lock_tmr_q   <= '0;
            settle_cnt_q <= '0;
            tx_cnt_q     <= '0;
            retry_q      <= '0;
            sel_q        <= 2'b00;
            fail_q       <= 1'b0;
            use_q        <= 1'b0;
`ifdef VPLL_LOCKLOSS_RECOVERY_EN
            loss_q       <= 1'b0;
            recover_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            lock_tmr_q   <= lock_tmr_d;
            settle_cnt_q <= settle_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            retry_q      <= retry_d;
            sel_q        <= sel_d;
            fail_q       <= fail_d;
            use_q        <= use_d;
`ifdef VPLL_LOCKLOSS_RECOVERY_EN
            loss_q       <= loss_d;
            recover_q    <= recover_d;
`endif
        end
    end

    // Next state; each counter only runs in its own state and idles at zero elsewhere
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = '0;
        lock_tmr_d   = '0;
        settle_cnt_d = '0;
        tx_cnt_d     = '0;
        retry_d      = retry_q;
        sel_d        = sel_q;
        fail_d       = fail_q && !(use_q && !USE_VPLL);
        use_d        = USE_VPLL;
`ifdef VPLL_LOCKLOSS_RECOVERY_EN
        loss_d       = (state_q == RUN_PLL) && !lock;
        recover_d    = (state_q == SW_BACK) && recover_q;
`endif
        case (state_q)
            BYPASS: begin
                tx_cnt_d = tx_cnt_q + TW'(tx_cnt_q < TW'(TX_POST));
                if (USE_VPLL && !fail_q) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            PLL_RST: begin
                rst_cnt_d = rst_cnt_q + RW'(rst_cnt_q != RW'(RST_CYCLES));
                if (!USE_VPLL) state_d = BYPASS;
                else if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                lock_tmr_d = lock_tmr_q + LW'(lock_tmr_q != LW'(LOCK_TIMEOUT));
                if (!USE_VPLL) state_d = BYPASS;
                else if (lock) state_d = SETTLE;
                else if (lock_tmr_q == LW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + NW'(retry_q != NW'(MAX_RETRY));
                    state_d = (retry_d < NW'(MAX_RETRY)) ? PLL_RST : BYPASS;
                    fail_d  = retry_d >= NW'(MAX_RETRY);
                end
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt_q + SW'(settle_cnt_q != SW'(SETTLE_CYCLES));
                if (!USE_VPLL) state_d = BYPASS;
                else if (!lock) state_d = WAIT_LOCK;
                else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) state_d = SW_PRE;
            end
            SW_PRE: begin
                tx_cnt_d = tx_cnt_q + TW'(tx_cnt_q != TW'(TX_ALL));
                if (tx_cnt_q == TW'(TX_PRE - 1)) begin
                    sel_d    = 2'b01;
                    tx_cnt_d = '0;
                    state_d  = SW_POST;
                end
            end
            SW_POST: begin
                tx_cnt_d = tx_cnt_q + TW'(tx_cnt_q != TW'(TX_ALL));
                if (tx_cnt_q == TW'(TX_POST - 1)) state_d = RUN_PLL;
            end
            RUN_PLL: begin
                if (!USE_VPLL) state_d = SW_BACK;
`ifdef VPLL_LOCKLOSS_RECOVERY_EN
                else if (!lock && loss_q) begin
                    state_d   = SW_BACK;
                    recover_d = 1'b1;
                    retry_d   = retry_q + NW'(retry_q != NW'(MAX_RETRY));
                end
`endif
            end
            SW_BACK: begin
                tx_cnt_d = tx_cnt_q + TW'(tx_cnt_q != TW'(TX_ALL));
                if (tx_cnt_q == TW'(TX_PRE - 1)) sel_d = 2'b00;
                if (tx_cnt_q == TW'(TX_ALL - 1)) begin
`ifdef VPLL_LOCKLOSS_RECOVERY_EN
                    state_d = (recover_q && USE_VPLL) ? PLL_RST : BYPASS;
`else
                    state_d = BYPASS;
`endif
                end
            end
        endcase
        if (state_d == BYPASS && state_q != BYPASS) tx_cnt_d = TW'(TX_POST);
    end

    // Outputs decoded from state; the post-reset Tx hold reuses the Tx counter in BYPASS
    always_comb begin
        VPLL_ARESET = (state_q == BYPASS) || (state_q == PLL_RST);
        TX_RST      = (state_q == SW_PRE) || (state_q == SW_POST) || (state_q == SW_BACK) ||
                      ((state_q == BYPASS) && (tx_cnt_q < TW'(TX_POST)));
        VPLL_ACTIVE = state_q == RUN_PLL;
        VCLK_SEL    = sel_q;
        VPLL_FAIL   = fail_q;
    end
endmodule

// File: tb/tb_n64adv_vpll_seq.sv
// tb_n64adv_vpll_seq: directed vector table plus multi-cycle sequences for the video PLL sequencer
module tb_n64adv_vpll_seq;
    typedef struct {
        logic       srst;
        logic       use_v;
        logic       lock;
        int         n;
        logic [5:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       srst, use_v, lock;
    logic       vpll_areset, tx_rst, vpll_active, vpll_fail;
    logic [1:0] vclk_sel;
    logic [5:0] outs;
    int         errors = 0;
    int         checks = 0;

    n64adv_vpll_seq #(
        .RST_CYCLES(16), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(256), .MAX_RETRY(3)
    ) dut (
        .SYS_CLK(clk), .SRST(srst), .USE_VPLL(use_v), .VPLL_LOCKED(lock),
        .VPLL_ARESET(vpll_areset), .VCLK_SEL(vclk_sel), .TX_RST(tx_rst),
        .VPLL_ACTIVE(vpll_active), .VPLL_FAIL(vpll_fail)
    );

    always #5 clk = ~clk;
    assign outs = {vclk_sel, vpll_areset, tx_rst, vpll_active, vpll_fail};

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // outputs packed as {sel[1:0], areset, tx_rst, active, fail}
    task automatic check6(input string nm, input logic [5:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: got sel/ar/tx/act/fail=%b want %b", nm, outs, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t v[17];
        int   falls, fail_at, sel_bad;
        logic prev_ar;
        // lock raised after the WAIT_LOCK entry edge: 3 edges to SETTLE, 256 settle, 4 pre, 8 post
        v[0]  = '{1'b0, 1'b0, 1'b0,   7, 6'b00_1_1_0_0};
        v[1]  = '{1'b0, 1'b0, 1'b0,   1, 6'b00_1_0_0_0};
        v[2]  = '{1'b0, 1'b1, 1'b0,   1, 6'b00_1_0_0_0};
        v[3]  = '{1'b0, 1'b1, 1'b0,  15, 6'b00_1_0_0_0};
        v[4]  = '{1'b0, 1'b1, 1'b0,   1, 6'b00_0_0_0_0};
        v[5]  = '{1'b0, 1'b1, 1'b1,   3, 6'b00_0_0_0_0};
        v[6]  = '{1'b0, 1'b1, 1'b1, 255, 6'b00_0_0_0_0};
        v[7]  = '{1'b0, 1'b1, 1'b1,   1, 6'b00_0_1_0_0};
        v[8]  = '{1'b0, 1'b1, 1'b1,   3, 6'b00_0_1_0_0};
        v[9]  = '{1'b0, 1'b1, 1'b1,   1, 6'b01_0_1_0_0};
        v[10] = '{1'b0, 1'b1, 1'b1,   7, 6'b01_0_1_0_0};
        v[11] = '{1'b0, 1'b1, 1'b1,   1, 6'b01_0_0_1_0};
        v[12] = '{1'b0, 1'b0, 1'b1,   1, 6'b01_0_1_0_0};
        v[13] = '{1'b0, 1'b0, 1'b1,   3, 6'b01_0_1_0_0};
        v[14] = '{1'b0, 1'b0, 1'b1,   1, 6'b00_0_1_0_0};
        v[15] = '{1'b0, 1'b0, 1'b1,   7, 6'b00_0_1_0_0};
        v[16] = '{1'b0, 1'b0, 1'b1,   1, 6'b00_1_0_0_0};
        srst = 1'b1; use_v = 1'b0; lock = 1'b0;
        @(negedge clk);
        run(3);
        check6("reset", 6'b00_1_1_0_0);
        for (int i = 0; i < 17; i++) begin
            srst = v[i].srst; use_v = v[i].use_v; lock = v[i].lock;
            run(v[i].n);
            check6($sformatf("vec%0d", i), v[i].exp);
        end
        // lock never arrives: 3 attempts of 16 reset + 100 wait, fail on edge 349
        use_v = 1'b1; lock = 1'b0;
        falls = 0; fail_at = 0; sel_bad = 0; prev_ar = vpll_areset;
        for (int i = 1; i <= 400; i++) begin
            run(1);
            if (prev_ar && !vpll_areset) falls++;
            if (vclk_sel != 2'b00) sel_bad++;
            if (vpll_fail && fail_at == 0) fail_at = i;
            prev_ar = vpll_areset;
        end
        check_int("retry_pulses", falls, 3);
        check_int("retry_fail_edge", fail_at, 349);
        check_int("retry_sel_moved", sel_bad, 0);
        check6("retry_end", 6'b00_1_0_0_1);
        for (int i = 0; i < 50; i++) begin
            run(1);
            if (prev_ar && !vpll_areset) falls++;
            prev_ar = vpll_areset;
        end
        check_int("fail_holds_off", falls, 3);
        use_v = 1'b0;
        run(1);
        check6("fail_clear", 6'b00_1_0_0_0);
        // abort from WAIT_LOCK
        use_v = 1'b1;
        run(20);
        check6("abort_wait", 6'b00_0_0_0_0);
        use_v = 1'b0;
        run(1);
        check6("abort_bypass", 6'b00_1_0_0_0);
        // one-cycle lock drop at settle count 100 restarts the settle window
        use_v = 1'b1;
        run(17);
        lock = 1'b1;
        run(103);
        lock = 1'b0;
        run(1);
        lock = 1'b1;
        run(262);
        check6("settle_restart_hold", 6'b00_0_1_0_0);
        run(1);
        check6("settle_restart_sw", 6'b01_0_1_0_0);
        run(8);
        check6("settle_restart_run", 6'b01_0_0_1_0);
        // lock loss while running
        lock = 1'b0;
        run(6);
`ifdef VPLL_LOCKLOSS_RECOVERY_EN
        check6("lockloss_back", 6'b01_0_1_0_0);
        run(10);
        check6("lockloss_pllrst", 6'b00_1_0_0_0);
`else
        check6("lockloss_ignored_a", 6'b01_0_0_1_0);
        run(10);
        check6("lockloss_ignored_b", 6'b01_0_0_1_0);
`endif
        use_v = 1'b0;
        run(14);
        check6("lockloss_exit", 6'b00_1_0_0_0);
        // SRST in the middle of SW_POST
        use_v = 1'b1; lock = 1'b1;
        run(278);
        check6("pre_srst_post", 6'b01_0_1_0_0);
        run(2);
        srst = 1'b1;
        run(1);
        check6("srst_mid_switch", 6'b00_1_1_0_0);
        srst = 1'b0; use_v = 1'b0;
        run(7);
        check6("srst_tx_hold", 6'b00_1_1_0_0);
        run(1);
        check6("srst_tx_release", 6'b00_1_0_0_0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
